dmem_arbiter: RTL and testbench

- Shares the single-port, 4-byte-lane data memory (four byte-wide banks, one per lane) between two requesters.
- Requester A is the RISC-V memory stage. Requester B is the auxiliary port, used by the filter-coefficient loader and the result readout engine.
- Fixed priority to A, with a starvation guard for B.
- Banks have synchronous read with one-cycle latency; the arbiter tracks the owner of each read so returned data is routed correctly.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/arb_starve_ctr.sv | 64 ++++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   owner_t : who owns the read currently returning from the banks
//   state_t : starvation-guard state (normal A priority, or one forced B cycle)
package dmem_arb_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = 8;
   localparam int unsigned DATA_W = LANES * LANE_W;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_A,
      OWN_B
   } owner_t;

   typedef enum logic {
      PRIO_A,
      FORCE_B
   } state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: starvation guard for the aux requester (B).
// Counts consecutive cycles in which B asks but is denied; after STARVE_MAX such cycles
// the next cycle is a FORCE_B cycle in which B wins over A. FORCE_B always lasts one cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_b_req        : B is requesting this cycle
//   i_b_gnt        : B was granted this cycle
//   o_force_b      : current cycle gives B priority
module arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_b_req,
   input  logic i_b_gnt,
   output logic o_force_b
);

   localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_denied;

   assign w_denied = i_b_req & ~i_b_gnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= PRIO_A;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      unique case (r_state)
         PRIO_A: begin
            if (w_denied) begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = FORCE_B;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         FORCE_B: begin
            // One forced cycle only, whether or not B is still asking.
            w_state_nxt = PRIO_A;
         end
      endcase
   end

   assign o_force_b = (r_state == FORCE_B);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port, 4-lane data memory between the core memory stage (A)
// and the aux port (B). A has fixed priority; B is force-granted for one cycle after
// STARVE_MAX consecutive denials. Reads return exactly one cycle after the grant and are
// steered to the requester that issued them.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_x_req/we/be/addr/wdata       : request from requester x (a or b), byte address
//   o_x_gnt                        : request accepted this cycle (combinational)
//   o_x_rvalid, o_x_rdata          : read return for requester x
//   o_m_en/we/addr/wdata, i_m_rdata: bank interface (synchronous read, 1-cycle latency)
// Optional build macro DMEM_ARB_STATS_EN adds o_a_stall_cnt, o_b_stall_cnt, o_force_cnt
// (saturating 16-bit counters of denied cycles and forced-B cycles).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DEPTH_W    = 10,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_a_req,
   input  logic               i_a_we,
   input  logic [LANES-1:0]   i_a_be,
   input  logic [31:0]        i_a_addr,
   input  logic [DATA_W-1:0]  i_a_wdata,
   output logic               o_a_gnt,
   output logic               o_a_rvalid,
   output logic [DATA_W-1:0]  o_a_rdata,
   input  logic               i_b_req,
   input  logic               i_b_we,
   input  logic [LANES-1:0]   i_b_be,
   input  logic [31:0]        i_b_addr,
   input  logic [DATA_W-1:0]  i_b_wdata,
   output logic               o_b_gnt,
   output logic               o_b_rvalid,
   output logic [DATA_W-1:0]  o_b_rdata,
   output logic               o_m_en,
   output logic [LANES-1:0]   o_m_we,
   output logic [DEPTH_W-1:0] o_m_addr,
   output logic [DATA_W-1:0]  o_m_wdata,
   input  logic [DATA_W-1:0]  i_m_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]        o_a_stall_cnt,
   output logic [15:0]        o_b_stall_cnt,
   output logic [15:0]        o_force_cnt
`endif
);

   logic   w_force_b;
   logic   w_a_gnt;
   logic   w_b_gnt;
   owner_t r_owner;
   owner_t w_owner_nxt;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;
   logic   w_unused_addr;

   // Byte offset and bits above the bank depth are dropped, so addresses wrap.
   assign w_unused_addr = ^{i_a_addr[31:DEPTH_W+2], i_a_addr[1:0],
                            i_b_addr[31:DEPTH_W+2], i_b_addr[1:0]};

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_b_req   (i_b_req),
      .i_b_gnt   (w_b_gnt),
      .o_force_b (w_force_b)
   );

   // A wins unless this is a forced cycle and B is asking; nothing is granted in reset.
   assign w_a_gnt = i_rst_n & i_a_req & ~(w_force_b & i_b_req);
   assign w_b_gnt = i_rst_n & i_b_req & ~w_a_gnt;
   assign o_a_gnt = w_a_gnt;
   assign o_b_gnt = w_b_gnt;

   always_comb begin
      o_m_en    = w_a_gnt | w_b_gnt;
      o_m_we    = '0;
      o_m_addr  = '0;
      o_m_wdata = '0;
      if (w_b_gnt) begin
         o_m_we    = i_b_we ? i_b_be : '0;
         o_m_addr  = i_b_addr[DEPTH_W+1:2];
         o_m_wdata = i_b_wdata;
      end else if (w_a_gnt) begin
         o_m_we    = i_a_we ? i_a_be : '0;
         o_m_addr  = i_a_addr[DEPTH_W+1:2];
         o_m_wdata = i_a_wdata;
      end
   end

   // Any granted read is a full-word read, regardless of byte enables.
   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (w_a_gnt & ~i_a_we) begin
         w_owner_nxt = OWN_A;
      end else if (w_b_gnt & ~i_b_we) begin
         w_owner_nxt = OWN_B;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner   <= OWN_NONE;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
      end else begin
         r_owner <= w_owner_nxt;
         if (r_owner == OWN_A) begin
            r_a_rdata <= i_m_rdata;
         end
         if (r_owner == OWN_B) begin
            r_b_rdata <= i_m_rdata;
         end
      end
   end

   // The bank data is live in the owner's return cycle; afterwards the captured copy
   // holds it, so each requester keeps its last read value.
   assign o_a_rvalid = (r_owner == OWN_A);
   assign o_b_rvalid = (r_owner == OWN_B);
   assign o_a_rdata  = o_a_rvalid ? i_m_rdata : r_a_rdata;
   assign o_b_rdata  = o_b_rvalid ? i_m_rdata : r_b_rdata;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] r_a_stall;
   logic [15:0] r_b_stall;
   logic [15:0] r_force;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a_stall <= '0;
         r_b_stall <= '0;
         r_force   <= '0;
      end else begin
         if (i_a_req & ~w_a_gnt & ~(&r_a_stall)) begin
            r_a_stall <= r_a_stall + 16'd1;
         end
         if (i_b_req & ~w_b_gnt & ~(&r_b_stall)) begin
            r_b_stall <= r_b_stall + 16'd1;
         end
         // FORCE_B lasts one cycle, so counting forced cycles counts entries.
         if (w_force_b & ~(&r_force)) begin
            r_force <= r_force + 16'd1;
         end
      end
   end

   assign o_a_stall_cnt = r_a_stall;
   assign o_b_stall_cnt = r_b_stall;
   assign o_force_cnt   = r_force;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model
// (priority rule, denial streak, word memory image, pending-read expectation).
module tb_dmem_arbiter;

   localparam int unsigned DW = 10;
   localparam int unsigned SM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req, a_we, b_req, b_we;
   logic [3:0]    a_be, b_be;
   logic [31:0]   a_addr, a_wdata, b_addr, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [31:0]   a_rdata, b_rdata;
   logic          m_en;
   logic [3:0]    m_we;
   logic [DW-1:0] m_addr;
   logic [31:0]   m_wdata, m_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   a_stall_cnt, b_stall_cnt, force_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .DEPTH_W    (DW),
      .STARVE_MAX (SM)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_a_req    (a_req),
      .i_a_we     (a_we),
      .i_a_be     (a_be),
      .i_a_addr   (a_addr),
      .i_a_wdata  (a_wdata),
      .o_a_gnt    (a_gnt),
      .o_a_rvalid (a_rvalid),
      .o_a_rdata  (a_rdata),
      .i_b_req    (b_req),
      .i_b_we     (b_we),
      .i_b_be     (b_be),
      .i_b_addr   (b_addr),
      .i_b_wdata  (b_wdata),
      .o_b_gnt    (b_gnt),
      .o_b_rvalid (b_rvalid),
      .o_b_rdata  (b_rdata),
      .o_m_en     (m_en),
      .o_m_we     (m_we),
      .o_m_addr   (m_addr),
      .o_m_wdata  (m_wdata),
      .i_m_rdata  (m_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .o_a_stall_cnt (a_stall_cnt),
      .o_b_stall_cnt (b_stall_cnt),
      .o_force_cnt   (force_cnt)
`endif
   );

   // Bank model: four byte lanes, write-first, synchronous read.
   logic [31:0] bank [1024];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (m_en) begin
         bank[m_addr] <= merge(bank[m_addr], m_wdata, m_we);
         m_rdata      <= merge(bank[m_addr], m_wdata, m_we);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [1024];
   int          streak = 0;       // consecutive cycles B asked and was refused
   int          exp_owner = 0;    // 0 none, 1 A, 2 B: who gets data next cycle
   logic [31:0] exp_data = '0;
   logic [31:0] exp_ar = '0;
   logic [31:0] exp_br = '0;
   int          n_astall = 0, n_bstall = 0, n_force = 0;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         bank[i]    = '0;
         ref_mem[i] = '0;
      end
   end

   always @(negedge clk) begin
      bit fnow, ea, eb, we;
      logic [3:0]  be;
      logic [31:0] ad, wd;
      int idx;
      if (!rst_n) begin
         chk("rst_a_gnt", a_gnt, 0);
         chk("rst_b_gnt", b_gnt, 0);
         chk("rst_m_en", m_en, 0);
         chk("rst_a_rvalid", a_rvalid, 0);
         chk("rst_b_rvalid", b_rvalid, 0);
         chk("rst_a_rdata", a_rdata, 0);
         chk("rst_b_rdata", b_rdata, 0);
         streak = 0; exp_owner = 0; exp_ar = '0; exp_br = '0;
         n_astall = 0; n_bstall = 0; n_force = 0;
`ifdef DMEM_ARB_STATS_EN
         chk("rst_force_cnt", force_cnt, 0);
`endif
      end else begin
         fnow = (streak >= SM);
         ea = a_req && !(fnow && b_req);
         eb = b_req && !ea;
         chk("a_gnt", a_gnt, ea);
         chk("b_gnt", b_gnt, eb);
         chk("m_en", m_en, ea || eb);
         chk("a_rvalid", a_rvalid, exp_owner == 1);
         chk("b_rvalid", b_rvalid, exp_owner == 2);
         if (exp_owner == 1) exp_ar = exp_data;
         if (exp_owner == 2) exp_br = exp_data;
         chk("a_rdata", a_rdata, exp_ar);
         chk("b_rdata", b_rdata, exp_br);
`ifdef DMEM_ARB_STATS_EN
         chk("a_stall_cnt", a_stall_cnt, n_astall);
         chk("b_stall_cnt", b_stall_cnt, n_bstall);
         chk("force_cnt", force_cnt, n_force);
`endif
         if (ea || eb) begin
            we = ea ? a_we : b_we;
            be = ea ? a_be : b_be;
            ad = ea ? a_addr : b_addr;
            wd = ea ? a_wdata : b_wdata;
            idx = int'((ad >> 2) % 1024);
            chk("m_addr", m_addr, idx);
            chk("m_we", m_we, we ? be : 4'b0000);
            if (we) begin
               chk("m_wdata", m_wdata, wd);
               for (int l = 0; l < 4; l++) if (be[l]) ref_mem[idx][8*l +: 8] = wd[8*l +: 8];
               exp_owner = 0;
            end else begin
               exp_owner = ea ? 1 : 2;
               exp_data  = ref_mem[idx];
            end
         end else begin
            chk("m_we_idle", m_we, 0);
            exp_owner = 0;
         end
         if (a_req && !ea) n_astall++;
         if (b_req && !eb) n_bstall++;
         if (fnow) n_force++;
         if (fnow) streak = 0;
         else if (b_req && !eb) streak++;
         else streak = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic set_a(input bit rq, input bit w, input logic [3:0] e, input logic [31:0] ad,
                        input logic [31:0] d);
      a_req = rq; a_we = w; a_be = e; a_addr = ad; a_wdata = d;
   endtask

   task automatic set_b(input bit rq, input bit w, input logic [3:0] e, input logic [31:0] ad,
                        input logic [31:0] d);
      b_req = rq; b_we = w; b_be = e; b_addr = ad; b_wdata = d;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] r;
      r = $urandom();
      return (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   initial begin
      bit ag, bg;
      rst_n = 1'b0;
      set_a(1, 0, 4'hF, 32'h0, 32'h0);
      set_b(1, 0, 4'hF, 32'h4, 32'h0);
      look();
      chk("lit_rst_a_gnt", a_gnt, 0);
      chk("lit_rst_m_en", m_en, 0);
      step();
      step();
      rst_n = 1'b1;
      look();
      chk("lit_first_gnt_a", a_gnt, 1);
      chk("lit_first_gnt_b", b_gnt, 0);

      // Solo A write then read.
      step(); set_a(1, 1, 4'hF, 32'h10, 32'hDEADBEEF); b_req = 0; look();
      step(); set_a(1, 0, 4'h0, 32'h10, 32'h0); look();
      chk("lit_solo_m_addr", m_addr, 4);
      step(); a_req = 0; look();
      chk("lit_solo_rvalid", a_rvalid, 1);
      chk("lit_solo_rdata", a_rdata, 32'hDEADBEEF);

      // B single-lane write, A reads the merged word.
      step(); set_b(1, 1, 4'b0100, 32'h10, 32'h00AA0000); look();
      chk("lit_lane_m_we", m_we, 4'b0100);
      step(); b_req = 0; set_a(1, 0, 4'hF, 32'h10, 32'h0); look();
      step(); a_req = 0; look();
      chk("lit_lane_rdata", a_rdata, 32'hDEAABEEF);

      // Contention: B wins every fifth cycle.
      for (int i = 0; i < 10; i++) begin
         step();
         set_a(1, 1, 4'hF, 32'h0, 32'h0A0A0A0A);
         set_b(1, 1, 4'hF, 32'h4, 32'h0B0B0B0B);
         look();
         chk("lit_contend_b_gnt", b_gnt, (i % 5) == 4);
      end

      // Interleaved reads returning A, B, A on consecutive cycles.
      for (int k = 0; k < 3; k++) begin
         step(); set_a(1, 0, 4'hF, 32'hC, 0); set_b(1, 0, 4'hF, 32'h4, 0); look();
      end
`ifdef DMEM_ARB_STATS_EN
      chk("lit_force_cnt", force_cnt, 2);
`endif
      step(); set_a(1, 0, 4'hF, 32'h0, 0); look();
      chk("lit_il_a_gnt", a_gnt, 1);
      step(); set_a(1, 0, 4'hF, 32'h8, 0); look();
      chk("lit_il_b_forced", b_gnt, 1);
      chk("lit_il_rv_a", a_rvalid, 1);
      chk("lit_il_rd_a", a_rdata, 32'h0A0A0A0A);
      step(); b_req = 0; look();
      chk("lit_il_rv_b", b_rvalid, 1);
      chk("lit_il_rd_b", b_rdata, 32'h0B0B0B0B);
      step(); a_req = 0; look();
      chk("lit_il_rv_a2", a_rvalid, 1);
      chk("lit_il_rd_a2", a_rdata, 32'h0);

      // Reset in the cycle after an A read grant.
      step(); set_a(1, 0, 4'hF, 32'h10, 0); set_b(1, 0, 4'hF, 32'h4, 0); look();
      chk("lit_mr_a_gnt", a_gnt, 1);
      #1 rst_n = 1'b0;
      look();
      chk("lit_mr_rvalid", a_rvalid, 0);
      step();
      step(); rst_n = 1'b1; look();
      chk("lit_mr_post_gnt_a", a_gnt, 1);
      chk("lit_mr_post_rvalid", a_rvalid, 0);
      for (int i = 1; i <= 4; i++) begin
         step(); look();
         chk("lit_mr_b_force", b_gnt, i == 4);
      end
      step(); a_req = 0; b_req = 0; look();

      // Randomized traffic; each requester holds its request until granted.
      ag = 1; bg = 1;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!a_req || ag)
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom()),
                  rnd_addr(), $urandom());
         if (!b_req || bg)
            set_b($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom()),
                  rnd_addr(), $urandom());
         look();
         ag = a_gnt; bg = b_gnt;
      end

      step(); a_req = 0; b_req = 0; look();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
